id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS datapath. It sits directly downstream of the opcode decoder. Each cycle it latches the decoder's WB/M/EX control groups together with the ID-stage operands, then presents them to the EX stage. It also detects load-use hazards, inserting a bubble and freezing PC and IF/ID, and zeroes control on a branch flush. A saturating stall counter is exposed for performance debug.

## Interface
- DW, 32, datapath width
- RW, 5, register-specifier width
- CW, 16, stall-counter width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wb_in  input  2  {RegWrite, MemtoReg}
- m_in  input  3  {Branch, MemRead, MemWrite}
- ex_in  input  4  {RegDst, ALUOp[1:0], ALUSrc}
- flush  input  1  taken branch resolved in MEM; kill the ID instruction
- npc_in, rd1_in, rd2_in, imm_in  input  DW each  PC+4, register file reads, sign-extended immediate
- rs_in, rt_in, rd_in  input  RW each  instr[25:21], [20:16], [15:11]
- wb_out  output  2  registered WB group
- m_out  output  3  registered M group
- ex_out  output  4  registered EX group
- npc_out, rd1_out, rd2_out, imm_out  output  DW each  registered data
- rs_out, rt_out, rd_out  output  RW each  registered specifiers
- pc_write  output  1  0 = hold PC
- ifid_write  output  1  0 = hold IF/ID
- stall_cnt  output  CW  count of bubble cycles, saturating

## Operation
- Hazard (combinational): hazard = m_out[1] & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
- pc_write = ifid_write = ~hazard | flush. A flush overrides the hold so that the fetch redirect proceeds.
- Control-register next value, priority order:
  - rst: 0.
  - flush: 0.
  - hazard: 0 (bubble).
  - otherwise: wb_in/m_in/ex_in.
- Data and specifier registers load every cycle except under rst, whose value is 0. Their contents under a bubble or flush are don't-care, because the zeroed control makes them inert.
- Stall counter: increments by 1 on each edge where hazard & ~flush. It holds at 2^CW-1 and never wraps. Reset value is 0.
- Bubble state: one stall inserts exactly one bubble. On the next cycle m_out[1]=0, so hazard deasserts automatically. Back-to-back loads each stall once.

## Timing
- Latency: in→out is 1 cycle.
- hazard, pc_write and ifid_write are same-cycle combinational outputs derived from the registered EX fields and the current ID inputs.
- Reset: asynchronous. All registered outputs = 0 and stall_cnt = 0 immediately. pc_write = ifid_write = 1 during and after reset.
- Reset asserted mid-stall: the bubble is discarded and the counter clears. The first edge after release latches the ID inputs normally.
- Simultaneous flush and hazard: the flush wins. Control = 0, pc_write = 1, and the counter does not increment.
- rt_out == 0 (load to $zero): no stall.

## Structure
- Shared package `pipe_pkg` holds:
  - WB_W=2, M_W=3, EX_W=4.
  - Bit-index constants: WB_REGWRITE=1, WB_MEMTOREG=0; M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0; EX_REGDST=3, EX_ALUOP_HI=2, EX_ALUOP_LO=1, EX_ALUSRC=0.
  - The decoder and every later pipeline register use these same constants.
- One sub-module is natural: `hazard_detect`, which is purely combinational and produces hazard, pc_write and ifid_write. The register bank and stall counter stay in `id_ex_stage`.

## Test plan
- Reset: assert rst mid-cycle with nonzero inputs. All outputs go to 0 asynchronously, stall_cnt=0, pc_write=1.
- Pass-through: wb_in=2'b10, m_in=3'b000, ex_in=4'b1100, rd1_in=32'h1234_5678, rt_in=5. After one edge, outputs match and no stall occurs.
- Load-use:
  - Cycle N: latch lw with m_in=3'b010, rt_in=8.
  - Next ID instruction has rs_in=8. In the same cycle pc_write=0 and ifid_write=0.
  - Next edge: wb_out/m_out/ex_out=0 and stall_cnt=1.
  - Following cycle: pc_write=1.
- $zero load: lw with rt=0 followed by rs_in=0. No stall occurs and stall_cnt is unchanged.
- Flush with hazard: set up the load-use case as above and assert flush in the same cycle. pc_write=1, the control outputs go to 0, and stall_cnt is unchanged.
- Saturation: with CW=4, force 20 stall cycles. stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control-group widths, bit positions and helpers
// Used by the decoder and by every pipeline register downstream of it.
package pipe_pkg;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   // WB group: {RegWrite, MemtoReg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // M group: {Branch, MemRead, MemWrite}
   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   // EX group: {RegDst, ALUOp[1:0], ALUSrc}
   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   typedef struct packed {
      logic [WB_W-1:0] wb;
      logic [M_W-1:0]  m;
      logic [EX_W-1:0] ex;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic logic is_memread(input logic [M_W-1:0] m);
      return m[M_MEMREAD];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection for the ID/EX boundary
// Ports:
//   ex_m      - M control group currently held in ID/EX (the EX-stage instruction)
//   ex_rt     - rt specifier currently held in ID/EX (load destination)
//   id_rs     - rs specifier of the instruction now in ID
//   id_rt     - rt specifier of the instruction now in ID
//   flush     - taken branch kills the ID instruction this cycle
//   hazard    - load-use dependency detected (raw, before flush masking)
//   pc_write  - 0 holds the PC
//   ifid_write- 0 holds the IF/ID register
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [M_W-1:0] ex_m,
   input  logic [RW-1:0]  ex_rt,
   input  logic [RW-1:0]  id_rs,
   input  logic [RW-1:0]  id_rt,
   input  logic           flush,
   output logic           hazard,
   output logic           pc_write,
   output logic           ifid_write
);

   logic rt_nonzero;
   logic rt_match;

   // A load into $zero never produces a usable value, so it never stalls.
   assign rt_nonzero = (ex_rt != '0);
   assign rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
   assign hazard     = is_memread(ex_m) && rt_nonzero && rt_match;

   // A flush must let the fetch redirect through even if the killed
   // instruction would otherwise have stalled.
   assign pc_write   = ~hazard | flush;
   assign ifid_write = ~hazard | flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and stall counter
// Ports:
//   clk, rst                      - rising-edge clock, async active-high reset
//   wb_in, m_in, ex_in            - decoder control groups for the ID instruction
//   flush                         - taken branch in MEM; kill the ID instruction
//   npc_in, rd1_in, rd2_in, imm_in- PC+4, register reads, sign-extended immediate
//   rs_in, rt_in, rd_in           - register specifiers of the ID instruction
//   wb_out, m_out, ex_out         - registered control groups presented to EX
//   npc_out .. rd_out             - registered data and specifiers
//   pc_write, ifid_write          - 0 = hold PC / IF/ID (combinational)
//   stall_cnt                     - saturating count of inserted bubbles
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WB_W-1:0] wb_in,
   input  logic [M_W-1:0]  m_in,
   input  logic [EX_W-1:0] ex_in,
   input  logic            flush,
   input  logic [DW-1:0]   npc_in,
   input  logic [DW-1:0]   rd1_in,
   input  logic [DW-1:0]   rd2_in,
   input  logic [DW-1:0]   imm_in,
   input  logic [RW-1:0]   rs_in,
   input  logic [RW-1:0]   rt_in,
   input  logic [RW-1:0]   rd_in,
   output logic [WB_W-1:0] wb_out,
   output logic [M_W-1:0]  m_out,
   output logic [EX_W-1:0] ex_out,
   output logic [DW-1:0]   npc_out,
   output logic [DW-1:0]   rd1_out,
   output logic [DW-1:0]   rd2_out,
   output logic [DW-1:0]   imm_out,
   output logic [RW-1:0]   rs_out,
   output logic [RW-1:0]   rt_out,
   output logic [RW-1:0]   rd_out,
   output logic            pc_write,
   output logic            ifid_write,
   output logic [CW-1:0]   stall_cnt
);

   logic  hazard;
   logic  stall;
   ctrl_t ctrl_q;
   ctrl_t ctrl_d;

   hazard_detect #(
      .RW(RW)
   ) u_hazard (
      .ex_m       (m_out),
      .ex_rt      (rt_out),
      .id_rs      (rs_in),
      .id_rt      (rt_in),
      .flush      (flush),
      .hazard     (hazard),
      .pc_write   (pc_write),
      .ifid_write (ifid_write)
   );

   // A real stall only happens when the hazard is not overridden by a flush.
   assign stall = hazard & ~flush;

   // Flush and bubble both zero the control; the data fields are then inert.
   always_comb begin
      ctrl_d = CTRL_NOP;
      if (!flush && !hazard) begin
         ctrl_d.wb = wb_in;
         ctrl_d.m  = m_in;
         ctrl_d.ex = ex_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign wb_out = ctrl_q.wb;
   assign m_out  = ctrl_q.m;
   assign ex_out = ctrl_q.ex;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         npc_out <= '0;
         rd1_out <= '0;
         rd2_out <= '0;
         imm_out <= '0;
         rs_out  <= '0;
         rt_out  <= '0;
         rd_out  <= '0;
      end else begin
         npc_out <= npc_in;
         rd1_out <= rd1_in;
         rd2_out <= rd2_in;
         imm_out <= imm_in;
         rs_out  <= rs_in;
         rt_out  <= rt_in;
         rd_out  <= rd_in;
      end
   end

   // Saturate at all-ones so a long debug run never wraps to a small value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CW{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
